// File: rtl/mac_dot_seq.sv
`timescale 1ns/1ps
// Operand sequencer and result collector for the 4-bit MAC accumulator stage.
// Frames each vector: clear, feed pairs, drain, capture sum, present result.
module mac_dot_seq #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_last,
    output logic [3:0]       mac_i,
    output logic [3:0]       mac_j,
    output logic             mac_clr_n,
    input  logic [8:0]       mac_f,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [8:0]       res_data,
    output logic [CNT_W-1:0] res_len,
    output logic             res_ovf
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned SUM_W = 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_CAPT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t             state_q;
    logic [OP_W-1:0]    mac_i_q;
    logic [OP_W-1:0]    mac_j_q;
    logic               clr_n_q;
    logic               res_valid_q;
    logic [SUM_W-1:0]   res_data_q;
    logic [CNT_W-1:0]   res_len_q;
    logic               res_ovf_q;
    logic [CNT_W-1:0]   count_q;
    logic [SUM_W-1:0]   acc_prev_q;
    logic               ovf_q;

    logic               accept;
    logic               wrap;
    logic [CNT_W-1:0]   cnt_inc;
    logic               last_hit;

    // Ready is forced low while reset is held so nothing is accepted mid-reset.
    assign in_ready = !rst && ((state_q == S_IDLE) || (state_q == S_RUN));
    assign accept   = in_valid && in_ready;
    // A product never exceeds 225, so a smaller sum than last cycle means a wrap.
    assign wrap     = (mac_f < acc_prev_q);
    assign cnt_inc  = count_q + CNT_W'(1);
    assign last_hit = in_last || (cnt_inc == CNT_W'(MAX_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mac_i_q     <= '0;
            mac_j_q     <= '0;
            clr_n_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_len_q   <= '0;
            res_ovf_q   <= 1'b0;
            count_q     <= '0;
            acc_prev_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            // MAC accumulates every edge; idle edges feed a zero product.
            mac_i_q <= '0;
            mac_j_q <= '0;
            case (state_q)
                S_IDLE: begin
                    clr_n_q    <= 1'b0;
                    acc_prev_q <= '0;
                    ovf_q      <= 1'b0;
                    count_q    <= '0;
                    if (accept) begin
                        mac_i_q <= in_a;
                        mac_j_q <= in_b;
                        clr_n_q <= 1'b1;
                        count_q <= CNT_W'(1);
                        state_q <= (in_last || (MAX_LEN == 1)) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    acc_prev_q <= mac_f;
                    ovf_q      <= ovf_q | wrap;
                    if (accept) begin
                        mac_i_q <= in_a;
                        mac_j_q <= in_b;
                        count_q <= cnt_inc;
                        if (last_hit) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    acc_prev_q <= mac_f;
                    ovf_q      <= ovf_q | wrap;
                    state_q    <= S_CAPT;
                end
                S_CAPT: begin
                    acc_prev_q  <= mac_f;
                    ovf_q       <= ovf_q | wrap;
                    res_data_q  <= mac_f;
                    res_len_q   <= count_q;
                    res_ovf_q   <= ovf_q | wrap;
                    res_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (res_valid_q && res_ready) begin
                        res_valid_q <= 1'b0;
                        clr_n_q     <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mac_i     = mac_i_q;
    assign mac_j     = mac_j_q;
    assign mac_clr_n = clr_n_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_len   = res_len_q;
    assign res_ovf   = res_ovf_q;

endmodule
